// File: rtl/aud_trace_sched.sv
// AUD trace capture controller: assembles AUDSYNC/AUDATA nibbles into {hdr, addr}
// frames, writes them to the trace FIFO and serves host reads with edge strobes.
module aud_trace_sched #(
   parameter int ADDRESS_WIDTH = 4,
   parameter int DATA_WIDTH    = 36
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     aud_stb_i,
   input  logic                     audsync_i,
   input  logic [3:0]               audata_i,
   output logic [DATA_WIDTH-1:0]    fifo_dat_o,
   output logic                     fifo_we_o,
   output logic                     fifo_re_o,
   input  logic [DATA_WIDTH-1:0]    fifo_dat_i,
   input  logic [ADDRESS_WIDTH:0]   fifo_count_i,
   input  logic                     rd_req_i,
   output logic                     rd_ack_o,
   output logic [DATA_WIDTH-1:0]    rd_dat_o,
   output logic                     ovf_o,
   input  logic                     ovf_clr_i,
   output logic [15:0]              frames_o
);

   localparam logic [ADDRESS_WIDTH:0] FULL_LEVEL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

   typedef enum logic {
      CAP_IDLE,
      CAP_ADDR
   } cap_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT,
      W_PULSE,
      W_GAP
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_PULSE,
      R_HOLD
   } rd_state_t;

   cap_state_t              cap_state_q, cap_state_d;
   wr_state_t               w_state_q, w_state_d;
   rd_state_t               r_state_q, r_state_d;

   logic [3:0]              hdr_q, hdr_d;
   // The last nibble goes straight into the frame word, so only 28 bits are held.
   logic [27:0]             addr_q, addr_d;
   logic [3:0]              target_q, target_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d;
   logic                    wr_req_q, wr_req_d;
   logic [15:0]             frames_q, frames_d;
   logic                    ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0]   rd_dat_q, rd_dat_d;

   logic                    frame_done;
   logic                    fifo_full;
   logic                    rd_go;
   logic [3:0]              cnt_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_state_q <= CAP_IDLE;
         w_state_q   <= W_IDLE;
         r_state_q   <= R_IDLE;
         hdr_q       <= '0;
         addr_q      <= '0;
         target_q    <= '0;
         cnt_q       <= '0;
         dat_q       <= '0;
         wr_req_q    <= 1'b0;
         frames_q    <= '0;
         ovf_q       <= 1'b0;
         rd_dat_q    <= '0;
      end else begin
         cap_state_q <= cap_state_d;
         w_state_q   <= w_state_d;
         r_state_q   <= r_state_d;
         hdr_q       <= hdr_d;
         addr_q      <= addr_d;
         target_q    <= target_d;
         cnt_q       <= cnt_d;
         dat_q       <= dat_d;
         wr_req_q    <= wr_req_d;
         frames_q    <= frames_d;
         ovf_q       <= ovf_d;
         rd_dat_q    <= rd_dat_d;
      end
   end

   assign fifo_full = (fifo_count_i == FULL_LEVEL);
   assign cnt_inc   = cnt_q + 4'd1;

   always_comb begin
      cap_state_d = cap_state_q;
      hdr_d       = hdr_q;
      addr_d      = addr_q;
      target_d    = target_q;
      cnt_d       = cnt_q;
      frame_done  = 1'b0;

      if (aud_stb_i) begin
         if (audsync_i) begin
            hdr_d       = audata_i;
            addr_d      = '0;
            cnt_d       = '0;
            cap_state_d = CAP_ADDR;
            case (audata_i[1:0])
               2'b00:   target_d = 4'd1;
               2'b01:   target_d = 4'd2;
               2'b10:   target_d = 4'd4;
               default: target_d = 4'd8;
            endcase
         end else if (cap_state_q == CAP_ADDR) begin
            addr_d = {addr_q[23:0], audata_i};
            cnt_d  = cnt_inc;
            if (cnt_inc == target_q) begin
               frame_done  = 1'b1;
               cap_state_d = CAP_IDLE;
            end
         end
      end
   end

   // Frame commit: a drop beats a same-cycle overflow clear.
   always_comb begin
      dat_d    = dat_q;
      frames_d = frames_q;
      ovf_d    = ovf_q;
      wr_req_d = wr_req_q && (w_state_q != W_IDLE);

      if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end
      if (frame_done) begin
         if (fifo_full) begin
            ovf_d = 1'b1;
         end else begin
            dat_d    = {hdr_q, addr_q, audata_i};
            wr_req_d = 1'b1;
            frames_d = frames_q + 16'd1;
         end
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE: begin
            if (wr_req_q) begin
               w_state_d = fifo_re_o ? W_WAIT : W_PULSE;
            end
         end
         W_WAIT:  w_state_d = W_PULSE;
         W_PULSE: w_state_d = W_GAP;
         W_GAP:   w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // A read may only start when no write is pending or about to pulse.
   assign rd_go = rd_req_i && (fifo_count_i != '0) && !wr_req_q &&
                  ((w_state_q == W_IDLE) || (w_state_q == W_GAP));

   always_comb begin
      r_state_d = r_state_q;
      rd_dat_d  = rd_dat_q;
      case (r_state_q)
         R_IDLE: begin
            if (rd_go) begin
               r_state_d = R_PULSE;
               rd_dat_d  = fifo_dat_i;
            end
         end
         R_PULSE: r_state_d = R_HOLD;
         R_HOLD: begin
            if (!rd_req_i) begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign fifo_dat_o = dat_q;
   assign fifo_we_o  = (w_state_q == W_PULSE);
   assign fifo_re_o  = (r_state_q == R_PULSE);
   assign rd_ack_o   = (r_state_q != R_IDLE);
   assign rd_dat_o   = rd_dat_q;
   assign ovf_o      = ovf_q;
   assign frames_o   = frames_q;

endmodule

// File: doc/aud_trace_sched.md
# aud_trace_sched

Capture-side controller for the AUD trace path. It assembles AUDSYNC/AUDATA nibble strobes into header+address frames and writes each complete frame into the trace FIFO. It also arbitrates the FIFO's edge-triggered write and read strobes against a host read handshake. It sits between the AUD pin synchronizer and the FIFO: it drives the FIFO's write data, write strobe and read strobe, and observes the FIFO's head data and fill count.

## Interface
Parameters:
- ADDRESS_WIDTH, default 4: FIFO address width; FIFO_DEPTH = 1 << ADDRESS_WIDTH.
- DATA_WIDTH, default 36: frame word width. Fixed layout {hdr[3:0], addr[31:0]}; must be 36.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- aud_stb_i  in  1  one-cycle strobe: audsync_i/audata_i valid this cycle. Successive strobes are ≥4 cycles apart.
- audsync_i  in  1  high = this nibble is a frame header.
- audata_i  in  4  trace nibble.
- fifo_dat_o  out  DATA_WIDTH  frame word presented to the FIFO write data.
- fifo_we_o  out  1  FIFO write strobe; the FIFO acts on its rising edge.
- fifo_re_o  out  1  FIFO read strobe; the FIFO acts on its rising edge.
- fifo_dat_i  in  DATA_WIDTH  FIFO head word, valid before a pop.
- fifo_count_i  in  ADDRESS_WIDTH+1  FIFO fill level.
- rd_req_i  in  1  host read request, 4-phase level handshake.
- rd_ack_o  out  1  host read acknowledge.
- rd_dat_o  out  DATA_WIDTH  popped word; stable while rd_ack_o is high.
- ovf_o  out  1  sticky flag: a frame was dropped because the FIFO was full.
- ovf_clr_i  in  1  one-cycle clear for ovf_o.
- frames_o  out  16  count of frames written, wraps modulo 2^16.

## Operation
Reset value of every output is 0.

Capture FSM (CAP_IDLE, CAP_ADDR):
- A strobe with audsync_i=1, in any state, starts a new frame:
  - hdr ← audata_i; addr ← 0.
  - Nibble target N from audata_i[1:0]: 00→1, 01→2, 10→4, 11→8.
  - Go to CAP_ADDR. A partial frame in progress is discarded and not counted.
- A strobe with audsync_i=0 in CAP_IDLE is ignored.
- A strobe with audsync_i=0 in CAP_ADDR shifts the nibble in MSB-first: addr ← {addr[27:0], audata_i}; the received-nibble count increments.
- When the count reaches N, the frame is complete:
  - If fifo_count_i == FIFO_DEPTH: drop the frame and set ovf_o.
  - Otherwise: fifo_dat_o ← {hdr, addr}, raise a write request, increment frames_o.
  - Return to CAP_IDLE.
- ovf_clr_i clears ovf_o. A drop in the same cycle as a clear wins, so ovf_o stays 1.

Write engine (W_IDLE, W_WAIT, W_PULSE, W_GAP):
- A request in W_IDLE goes to W_PULSE if fifo_re_o is 0 this cycle, otherwise to W_WAIT.
- W_WAIT → W_PULSE on the next cycle.
- W_PULSE: fifo_we_o=1 for exactly one cycle.
- W_GAP: fifo_we_o=0 for one cycle, then W_IDLE.
- fifo_dat_o stays constant from the load edge until W_GAP ends.

Read engine (R_IDLE, R_PULSE, R_HOLD):
- R_IDLE → R_PULSE when all hold: rd_req_i=1, fifo_count_i≠0, write engine in W_IDLE or W_GAP, and no write request raised this cycle.
- Entering R_PULSE: rd_dat_o ← fifo_dat_i; fifo_re_o=1 and rd_ack_o=1.
- R_PULSE → R_HOLD: fifo_re_o=0; rd_ack_o stays 1.
- R_HOLD → R_IDLE when rd_req_i=0, and rd_ack_o drops.
- If rd_req_i=1 and the FIFO is empty, the request waits with no ack.

Invariants:
- fifo_we_o and fifo_re_o are never 1 in the same cycle.
- Each strobe is low for ≥1 cycle between pulses.
- Writes have priority over reads.

## Timing
- Last nibble strobe at edge T:
  - fifo_dat_o loaded at T.
  - fifo_we_o high T+1 to T+2 (or T+2 to T+3 if delayed by an active read pulse).
  - frames_o increments at T.
- Read: rd_req_i seen high at edge R with the conditions met → fifo_re_o and rd_ack_o rise at R+1; fifo_re_o falls at R+2.
- Full check uses fifo_count_i at the completion edge. Strobe spacing ≥4 guarantees the FIFO count has settled from the previous write.
- Reset (rst_n low) at any time: all FSMs idle, partial frame discarded, outputs 0, immediately and asynchronously.

## Test plan
- Header 0x2, then nibbles A,B,C,D → one fifo_we_o pulse with fifo_dat_o = 0x20000ABCD; frames_o = 1.
- Header 0x3, three nibbles, then a new header 0x0 and nibble 5 → only 0x000000005 is written; frames_o = 1.
- Fill the FIFO to 16 frames, then send frame 17 → no fifo_we_o pulse, ovf_o = 1, frames_o = 16; ovf_clr_i → ovf_o = 0.
- FIFO holds 0x100000007; raise rd_req_i → rd_dat_o = 0x100000007, one fifo_re_o pulse, rd_ack_o held until rd_req_i drops.
- Frame completes in the same cycle the read engine pulses fifo_re_o → fifo_we_o is delayed one cycle and never overlaps fifo_re_o.
- Assert rst_n low mid-frame and mid-handshake → all outputs 0; the next full frame is captured correctly.
